// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, address-width helper and address validity check for reg_file_param.
package rf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int ZERO_ADDR      = 0;

    typedef logic [DEFAULT_DATA_W-1:0] word_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // An address names a real register unless it is past the array or is the hardwired zero register.
    function automatic logic addr_ok(input int a, input int depth, input int zero_reg);
        return (a < depth) && !(zero_reg != 0 && a == ZERO_ADDR);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port (array mux, range/zero check, output register).
// Same-cycle write forwarding is compiled in when RF_BYPASS_EN is defined.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = addr_w(DEPTH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_i [DEPTH],
    input  logic [DEPTH-1:0]  busy_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
`ifdef RF_BYPASS_EN
    input  logic              wr_ok_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rs_ok_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
`endif
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    logic              rd_ok;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_d, busy_q;

    always_comb begin
        rd_ok  = addr_ok(int'(addr_i), DEPTH, ZERO_REG);
        data_d = rd_ok ? mem_i[addr_i] : '0;
        busy_d = rd_ok && busy_i[addr_i];
`ifdef RF_BYPASS_EN
        if (rd_ok && wr_ok_i && wr_addr_i == addr_i) begin
            data_d = wr_data_i;
            busy_d = rs_ok_i && rs_addr_i == addr_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else if (en_i) begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-read register file with registered reads and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    localparam int ADDR_W    = addr_w(DEPTH)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] readReg,
    input  logic                     RegRead,
    output logic [NUM_RD*DATA_W-1:0] regOut,
    output logic [NUM_RD-1:0]        readBusy,
    output logic                     readValid,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        reserveReg,
    input  logic                     RegReserve,
    output logic [DEPTH-1:0]         busyVec
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_d, busy_q;
    logic              valid_q;
    logic              wr_ok, rs_ok;

    // Reserve is applied after the write clear so a new producer wins over a retiring one.
    always_comb begin
        wr_ok  = RegWrite && addr_ok(int'(writeReg), DEPTH, ZERO_REG);
        rs_ok  = RegReserve && addr_ok(int'(reserveReg), DEPTH, ZERO_REG);
        busy_d = busy_q;
        if (wr_ok) busy_d[writeReg] = 1'b0;
        if (rs_ok) busy_d[reserveReg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            busy_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_ok) mem_q[writeReg] <= writeData;
            busy_q  <= busy_d;
            valid_q <= RegRead;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ZERO_REG(ZERO_REG),
            .ADDR_W  (ADDR_W)
        ) u_rd (
            .clk      (clk),
            .rst_n    (rst_n),
            .mem_i    (mem_q),
            .busy_i   (busy_q),
            .addr_i   (readReg[i*ADDR_W +: ADDR_W]),
            .en_i     (RegRead),
`ifdef RF_BYPASS_EN
            .wr_ok_i  (wr_ok),
            .wr_addr_i(writeReg),
            .wr_data_i(writeData),
            .rs_ok_i  (rs_ok),
            .rs_addr_i(reserveReg),
`endif
            .data_o   (regOut[i*DATA_W +: DATA_W]),
            .busy_o   (readBusy[i])
        );
    end

    assign busyVec   = busy_q;
    assign readValid = valid_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks on a default instance and a DEPTH=20/NUM_RD=3/ZERO_REG=0 instance.
module tb_reg_file_param;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  a_rd = '0;
    logic        a_re = 1'b0, a_rv, a_we = 1'b0, a_rs = 1'b0;
    logic [63:0] a_out;
    logic [1:0]  a_rb;
    logic [4:0]  a_wa = '0, a_ra = '0;
    logic [31:0] a_wd = '0, a_bv;

    logic [14:0] b_rd = '0;
    logic        b_re = 1'b0, b_rv, b_we = 1'b0, b_rs = 1'b0;
    logic [95:0] b_out;
    logic [2:0]  b_rb;
    logic [4:0]  b_wa = '0, b_ra = '0;
    logic [31:0] b_wd = '0;
    logic [19:0] b_bv;

    int checks = 0;
    int errors = 0;

    reg_file_param u_a (
        .clk(clk), .rst_n(rst_n), .readReg(a_rd), .RegRead(a_re), .regOut(a_out),
        .readBusy(a_rb), .readValid(a_rv), .writeReg(a_wa), .writeData(a_wd),
        .RegWrite(a_we), .reserveReg(a_ra), .RegReserve(a_rs), .busyVec(a_bv)
    );

    reg_file_param #(.DEPTH(20), .NUM_RD(3), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .readReg(b_rd), .RegRead(b_re), .regOut(b_out),
        .readBusy(b_rb), .readValid(b_rv), .writeReg(b_wa), .writeData(b_wd),
        .RegWrite(b_we), .reserveReg(b_ra), .RegReserve(b_rs), .busyVec(b_bv)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_re = 0; a_we = 0; a_rs = 0;
        b_re = 0; b_we = 0; b_rs = 0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        chk("reset_regout", a_out, 0);
        chk("reset_valid", a_rv, 0);
        chk("reset_busyvec", a_bv, 0);
        tick();
        // write r5 then read it back before resetting
        a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF;
        tick();
        idle();
        a_rd = {5'd0, 5'd5}; a_re = 1; a_rs = 1; a_ra = 3;
        tick();
        chk("pre_reset_r5", a_out[31:0], 32'hDEADBEEF);
        chk("pre_reset_valid", a_rv, 1);
        chk("pre_reset_busy_r3", a_bv, 32'h8);
        a_rs = 0;
        a_we = 1; a_wa = 6; a_wd = 32'h66;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_regout", a_out, 0);
        chk("async_reset_busyvec", a_bv, 0);
        chk("async_reset_valid", a_rv, 0);
        idle();
        #1 rst_n = 1'b1;
        a_rd = {5'd6, 5'd5}; a_re = 1;
        tick();
        chk("post_reset_r5_r6", a_out, 0);
        chk("post_reset_valid", a_rv, 1);
        // zero register: hardwired in u_a, ordinary in u_b
        idle();
        a_we = 1; a_wa = 0; a_wd = 32'h1; a_rs = 1; a_ra = 0;
        b_we = 1; b_wa = 0; b_wd = 32'h1;
        tick();
        chk("zero_reserve_ignored", a_bv, 0);
        idle();
        a_rd = {5'd0, 5'd0}; a_re = 1;
        b_rd = {5'd0, 5'd0, 5'd0}; b_re = 1;
        tick();
        chk("zero_reg_read", a_out, 0);
        chk("zero_reg_busy", a_rb, 0);
        chk("nonzero_reg0_read", b_out, {32'h1, 32'h1, 32'h1});
        // latency and hold
        idle();
        a_we = 1; a_wa = 7; a_wd = 32'h12345678;
        tick();
        chk("valid_low_no_read", a_rv, 0);
        idle();
        a_rd = {5'd7, 5'd3}; a_re = 1;
        tick();
        chk("latency_regout", a_out, {32'h12345678, 32'h0});
        chk("latency_valid", a_rv, 1);
        idle();
        a_rd = {5'd0, 5'd0};
        tick();
        chk("hold_regout", a_out, {32'h12345678, 32'h0});
        chk("hold_valid", a_rv, 0);
        // scoreboard
        a_rs = 1; a_ra = 9;
        tick();
        chk("reserve_r9", a_bv, 32'h200);
        idle();
        a_rd = {5'd7, 5'd9}; a_re = 1;
        tick();
        chk("read_busy_r9", a_rb, 2'b01);
        idle();
        a_we = 1; a_wa = 9; a_wd = 32'hA5;
        tick();
        chk("write_clears_r9", a_bv, 0);
        a_wd = 32'h5A; a_rs = 1; a_ra = 9;
        tick();
        chk("reserve_wins_r9", a_bv, 32'h200);
        idle();
        a_rd = {5'd0, 5'd9}; a_re = 1;
        tick();
        chk("reserve_wins_data", a_out[31:0], 32'h5A);
        chk("reserve_wins_rbusy", a_rb, 2'b01);
        // same-cycle read/write of r4
        idle();
        a_we = 1; a_wa = 4; a_wd = 32'h11;
        tick();
        a_wd = 32'h22; a_rd = {5'd0, 5'd4}; a_re = 1;
        tick();
        chk("rw_same_data", a_out[31:0], BYP ? 32'h22 : 32'h11);
        chk("rw_same_busy", a_rb, 2'b00);
        a_wd = 32'h33; a_rs = 1; a_ra = 4;
        tick();
        chk("rw_res_same_data", a_out[31:0], BYP ? 32'h33 : 32'h22);
        chk("rw_res_same_busy", a_rb, BYP ? 2'b01 : 2'b00);
        // DEPTH=20, three ports
        idle();
        b_we = 1; b_wa = 1; b_wd = 32'hAAAA1111;
        tick();
        b_wa = 19; b_wd = 32'hBBBB;
        tick();
        b_wa = 25; b_wd = 32'hFFFF; b_rs = 1; b_ra = 25;
        tick();
        chk("oob_reserve_ignored", b_bv, 0);
        idle();
        b_rd = {5'd19, 5'd1, 5'd1}; b_re = 1;
        tick();
        chk("three_port_read", b_out, {32'hBBBB, 32'hAAAA1111, 32'hAAAA1111});
        chk("three_port_valid", b_rv, 1);
        b_rd = {5'd25, 5'd1, 5'd25};
        tick();
        chk("oob_read", b_out, {32'h0, 32'hAAAA1111, 32'h0});
        chk("oob_busy", b_rb, 3'b000);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
